mem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the 16x16 memory block.
//  - Accepts single-beat read/write commands from two masters.
//  - Grants one at a time and drives the memory cs/op_en/wr_en/addr_in/data_in strobes.
//  - Returns each completion with a one-cycle response pulse; captures data_out for reads.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 20 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter.
package mem_arb_pkg;

  // Sequencer states: accept in IDLE, drive strobes in ISSUE, count read latency in WAIT.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_MEM_RD_LAT = 1;

  // One-hot encoding of a requester index, used for gnt and rsp_valid.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way picker. The "last granted" pointer is held by the caller;
// with fixed_prio set, requester 0 always wins a tie and last is ignored.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       winner
);

  // Tie goes to the requester not granted last (or to 0 under fixed priority).
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = fixed_prio ? 1'b0 : ~last;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port memory.
// One transaction in flight; a write completes 2 cycles after its request is
// seen, a read 2+MEM_RD_LAT cycles after.
// Build option: MEM_ARB_FIXED_PRIO_EN selects strict priority (requester 0 wins
// ties, no round-robin pointer); left undefined, ties alternate round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_RD_LAT = DEF_MEM_RD_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                mem_cs,
  output logic                mem_op_en,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // Counter must hold MEM_RD_LAT itself; it counts down to 1.
  localparam int CNT_W = (MEM_RD_LAT < 1) ? 1 : $clog2(MEM_RD_LAT + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cur;
  logic [1:0]          r_gnt;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_cs;
  logic                r_op_en;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_winner;
  logic                w_any;
  logic                w_last;
  logic                w_fixed;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_any = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_last  = 1'b1;
  assign w_fixed = 1'b1;
`else
  logic r_last;

  // Round-robin pointer: remembers the requester granted most recently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && w_any) begin
      r_last <= w_winner;
    end
  end

  assign w_last  = r_last;
  assign w_fixed = 1'b0;
`endif

  mem_arb_rr u_rr (
    .req        (req),
    .last       (w_last),
    .fixed_prio (w_fixed),
    .winner     (w_winner)
  );

  // Command fields of the winning requester.
  assign w_sel_we    = w_winner ? req_we[1] : req_we[0];
  assign w_sel_addr  = w_winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Sequencer: arbitrate in IDLE, strobe memory for one cycle, wait out read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cur       <= 1'b0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_cs        <= 1'b0;
      r_op_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      // Completion is a single-cycle pulse.
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= onehot2(w_winner);
            r_cs    <= 1'b1;
            r_op_en <= 1'b1;
            r_wr_en <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cur   <= w_winner;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory samples the command at the end of this cycle; address/data hold.
          r_gnt   <= '0;
          r_cs    <= 1'b0;
          r_op_en <= 1'b0;
          r_wr_en <= 1'b0;
          if (r_wr_en) begin
            r_rsp_valid[r_cur] <= 1'b1;
            r_state            <= IDLE;
          end else begin
            r_cnt   <= CNT_W'(MEM_RD_LAT);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_data         <= mem_rdata;
            r_rsp_valid[r_cur] <= 1'b1;
            r_state            <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_cs    = r_cs;
  assign mem_op_en = r_op_en;
  assign mem_wr_en = r_wr_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with read latency 1 and one
// with read latency 3, each backed by a small behavioural memory.
module tb_mem_arbiter;

  typedef struct {
    int          idx;
    bit          we;
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;

  // instance with MEM_RD_LAT=1
  logic [1:0]  req = '0, req_we = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  gnt, rsp_valid;
  logic [15:0] rsp_data, mem_wdata, mem_rdata;
  logic        mem_cs, mem_op_en, mem_wr_en;
  logic [3:0]  mem_addr;

  // instance with MEM_RD_LAT=3
  logic [1:0]  req3 = '0, req_we3 = '0;
  logic [7:0]  req_addr3 = '0;
  logic [31:0] req_wdata3 = '0;
  logic [1:0]  gnt3, rsp_valid3;
  logic [15:0] rsp_data3, mem_wdata3, mem_rdata3;
  logic        mem_cs3, mem_op_en3, mem_wr_en3;
  logic [3:0]  mem_addr3;

  exp_t gq[$], rq[$], gq3[$], rq3[$];
  logic [15:0] sh1 [16];
  logic [15:0] sh3 [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(4), .DATA_W(16), .MEM_RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_cs(mem_cs), .mem_op_en(mem_op_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_arbiter #(.ADDR_W(4), .DATA_W(16), .MEM_RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_we(req_we3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .mem_cs(mem_cs3), .mem_op_en(mem_op_en3), .mem_wr_en(mem_wr_en3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3));

  // Behavioural memories: 1-cycle registered read, and a 3-stage read pipeline.
  logic [15:0] mem1 [16];
  logic [15:0] mem3 [16];
  logic [15:0] rd1, p0, p1, p2;
  always @(posedge clk) begin
    if (mem_cs && mem_op_en) begin
      if (mem_wr_en) mem1[mem_addr] <= mem_wdata;
      else           rd1 <= mem1[mem_addr];
    end
    if (mem_cs3 && mem_op_en3) begin
      if (mem_wr_en3) mem3[mem_addr3] <= mem_wdata3;
      else            p0 <= mem3[mem_addr3];
    end
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata  = rd1;
  assign mem_rdata3 = p2;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor for the latency-1 instance: pops expected grants and responses.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("strobe_vs_gnt", {31'd0, mem_cs}, {31'd0, gnt != 2'b00});
      chk("op_en_vs_cs", {31'd0, mem_op_en}, {31'd0, mem_cs});
      if (gnt != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
        else begin
          e = gq.pop_front();
          $display("GNT  lat1 req%0d we=%0d addr=%0d cyc=%0d", e.idx, e.we, e.addr, cyc);
          chk("gnt_value", {30'd0, gnt}, (e.idx == 1) ? 32'd2 : 32'd1);
          chk("gnt_cycle", cyc, e.cyc);
          chk("gnt_wr_en", {31'd0, mem_wr_en}, {31'd0, e.we});
          chk("gnt_addr", {28'd0, mem_addr}, {28'd0, e.addr});
          if (e.we) chk("gnt_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
        end
      end
      if (rsp_valid != 2'b00) begin
        rsp_seen++;
        if (rq.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        else begin
          e = rq.pop_front();
          $display("RSP  lat1 req%0d we=%0d addr=%0d data=%h cyc=%0d", e.idx, e.we, e.addr, rsp_data, cyc);
          chk("rsp_value", {30'd0, rsp_valid}, (e.idx == 1) ? 32'd2 : 32'd1);
          chk("rsp_cycle", cyc, e.cyc);
          if (!e.we) chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
        end
      end
    end
  end

  // Monitor for the latency-3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("strobe_vs_gnt3", {31'd0, mem_cs3}, {31'd0, gnt3 != 2'b00});
      if (gnt3 != 2'b00) begin
        if (gq3.size() == 0) chk("gnt3_unexpected", {30'd0, gnt3}, 32'd0);
        else begin
          e = gq3.pop_front();
          $display("GNT  lat3 req%0d we=%0d addr=%0d cyc=%0d", e.idx, e.we, e.addr, cyc);
          chk("gnt3_value", {30'd0, gnt3}, (e.idx == 1) ? 32'd2 : 32'd1);
          chk("gnt3_cycle", cyc, e.cyc);
          chk("gnt3_wr_en", {31'd0, mem_wr_en3}, {31'd0, e.we});
        end
      end
      if (rsp_valid3 != 2'b00) begin
        if (rq3.size() == 0) chk("rsp3_unexpected", {30'd0, rsp_valid3}, 32'd0);
        else begin
          e = rq3.pop_front();
          $display("RSP  lat3 req%0d we=%0d addr=%0d data=%h cyc=%0d", e.idx, e.we, e.addr, rsp_data3, cyc);
          chk("rsp3_value", {30'd0, rsp_valid3}, (e.idx == 1) ? 32'd2 : 32'd1);
          chk("rsp3_cycle", cyc, e.cyc);
          if (!e.we) chk("rsp3_data", {16'd0, rsp_data3}, {16'd0, e.data});
        end
      end
    end
  end

  // Wait (bounded) until requester idx of the selected instance sees its grant.
  task automatic wait_gnt(input bit d3, input int idx);
    bit got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = d3 ? gnt3[idx] : gnt[idx];
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL gnt_timeout actual=none expected=gnt%0d", idx);
    end
  endtask

  // Wait (bounded) until every scoreboard queue is drained.
  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      done = (gq.size() == 0) && (rq.size() == 0) && (gq3.size() == 0) && (rq3.size() == 0);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 outstanding",
               gq.size() + rq.size() + gq3.size() + rq3.size());
      gq.delete(); rq.delete(); gq3.delete(); rq3.delete();
    end
  endtask

  // Single command on an idle instance; expectations derived from the latency rules.
  task automatic do_req(input bit d3, input int idx, input bit we, input logic [3:0] a, input logic [15:0] d);
    int t;
    int lat;
    logic [15:0] ed;
    @(posedge clk); #1;
    t   = cyc;
    lat = d3 ? 3 : 1;
    ed  = we ? d : (d3 ? sh3[a] : sh1[a]);
    if (we) begin
      if (d3) sh3[a] = d; else sh1[a] = d;
    end
    if (d3) begin
      gq3.push_back('{idx, we, a, d, t + 1});
      rq3.push_back('{idx, we, a, ed, t + 2 + (we ? 0 : lat)});
      req_we3[idx] = we; req_addr3[idx*4 +: 4] = a; req_wdata3[idx*16 +: 16] = d; req3[idx] = 1'b1;
    end else begin
      gq.push_back('{idx, we, a, d, t + 1});
      rq.push_back('{idx, we, a, ed, t + 2 + (we ? 0 : lat)});
      req_we[idx] = we; req_addr[idx*4 +: 4] = a; req_wdata[idx*16 +: 16] = d; req[idx] = 1'b1;
    end
    wait_gnt(d3, idx);
    @(posedge clk); #1;
    if (d3) req3[idx] = 1'b0; else req[idx] = 1'b0;
    wait_idle();
  endtask

  // Requester holding writes to its half of the address space, advancing on each grant.
  task automatic drive_stream(input int idx);
    logic [3:0] a;
    for (int j = 0; j < 8; j++) begin
      a = 4'(2 * j + idx);
      req_we[idx] = 1'b1;
      req_addr[idx*4 +: 4] = a;
      req_wdata[idx*16 +: 16] = 16'h4000 | {12'd0, a};
      req[idx] = 1'b1;
      wait_gnt(1'b0, idx);
      @(posedge clk); #1;
    end
    req[idx] = 1'b0;
  endtask

  initial begin
    int t0;
    int idx;
    logic [3:0] a;
    logic [15:0] d;
    int seen;

    // Reset state
    #3;
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_strobes", {29'd0, mem_cs, mem_op_en, mem_wr_en}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_gnt3", {30'd0, gnt3}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset during a read's WAIT cycle aborts it with no response
    @(posedge clk); #1;
    t0 = cyc;
    gq.push_back('{0, 1'b0, 4'd5, 16'd0, t0 + 1});
    req_we[0] = 1'b0; req_addr[3:0] = 4'd5; req[0] = 1'b1;
    wait_gnt(1'b0, 0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("abort_gnt", {30'd0, gnt}, 32'd0);
    chk("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("abort_strobes", {29'd0, mem_cs, mem_op_en, mem_wr_en}, 32'd0);
    chk("abort_mem_addr", {28'd0, mem_addr}, 32'd0);
    seen = rsp_seen;
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_rsp", seen, rsp_seen);
    chk("abort_queue_empty", gq.size() + rq.size(), 32'd0);

    // 2: write from requester 0; 3: read back from requester 1
    do_req(1'b0, 0, 1'b1, 4'd3, 16'hA5A5);
    do_req(1'b0, 1, 1'b0, 4'd3, 16'h0000);
    chk("t3_rsp_data_hold", {16'd0, rsp_data}, 32'h0000A5A5);

    // 4: both requesters held, back-to-back writes to addresses 0..15
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      idx = (k < 8) ? 0 : 1;
      a   = (k < 8) ? 4'(2 * k) : 4'(2 * (k - 8) + 1);
`else
      idx = k % 2;
      a   = 4'(k);
`endif
      d = 16'h4000 | {12'd0, a};
      sh1[a] = d;
      gq.push_back('{idx, 1'b1, a, d, t0 + 1 + 2 * k});
      rq.push_back('{idx, 1'b1, a, d, t0 + 2 + 2 * k});
    end
    fork
      drive_stream(0);
      drive_stream(1);
    join
    wait_idle();
    do_req(1'b0, 0, 1'b0, 4'd9, 16'h0000);

    // 5: read latency 3 instance: write then read
    do_req(1'b1, 1, 1'b1, 4'd7, 16'h1234);
    do_req(1'b1, 0, 1'b0, 4'd7, 16'h0000);
    do_req(1'b1, 1, 1'b0, 4'd15, 16'h0000);

    // 6: fill with random words, then read back with the other requester
    for (int i = 0; i < 16; i++)
      do_req(1'b0, i % 2, 1'b1, 4'(i), 16'($urandom));
    for (int i = 0; i < 16; i++)
      do_req(1'b0, (i + 1) % 2, 1'b0, 4'(i), 16'h0000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
